// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - single-port data memory sequencer/arbiter for pipeline MA stage and debug port
module dmem_access_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ma_req,
    input  logic              ma_we,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic [DATA_W-1:0] ma_wdata,
    output logic              ma_ready,
    output logic [DATA_W-1:0] ma_rdata,
    output logic              ma_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic       ID_MA    = 1'b0;
    localparam logic       ID_DBG   = 1'b1;
    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t              state;
    state_t              state_nxt;
    logic                last_grant;
    logic                lat_id;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [1:0]          cnt;
    logic                grant;
    logic                grant_id;

    // Round-robin: on a tie the port that did not win last time is served.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_id  = ID_MA;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        ma_ready  = 1'b0;
        dbg_ready = 1'b0;
        case (state)
            IDLE: begin
                if (ma_req && (!dbg_req || last_grant == ID_DBG)) begin
                    grant    = 1'b1;
                    grant_id = ID_MA;
                end else if (dbg_req) begin
                    grant    = 1'b1;
                    grant_id = ID_DBG;
                end
                if (grant) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = lat_we;
                state_nxt = lat_we ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                ma_ready  = (lat_id == ID_MA);
                dbg_ready = (lat_id == ID_DBG);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= ID_DBG;
            lat_id     <= ID_MA;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= 2'd0;
            ma_rdata   <= '0;
            dbg_rdata  <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                lat_id     <= grant_id;
                last_grant <= grant_id;
                lat_we     <= (grant_id == ID_DBG) ? dbg_we    : ma_we;
                lat_addr   <= (grant_id == ID_DBG) ? dbg_addr  : ma_addr;
                lat_wdata  <= (grant_id == ID_DBG) ? dbg_wdata : ma_wdata;
            end
            if (state == ISSUE && !lat_we) begin
                cnt <= CNT_INIT;
            end
            // Final WAIT cycle lands exactly RD_LAT edges after the ISSUE edge.
            if (state == WAIT) begin
                if (cnt == 2'd0) begin
                    if (lat_id == ID_DBG) begin
                        dbg_rdata <= mem_dout;
                    end else begin
                        ma_rdata <= mem_dout;
                    end
                end else begin
                    cnt <= cnt - 2'd1;
                end
            end
        end
    end

    assign mem_addr = lat_addr;
    assign mem_din  = lat_wdata;
    assign ma_stall = ma_req & ~ma_ready;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - randomized and directed bench for dmem_access_ctrl at RD_LAT 1 and 3
module tb_dmem_access_ctrl;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       ma_req, ma_we, dbg_req, dbg_we;
    logic [1:0][6:0]  ma_addr, dbg_addr;
    logic [1:0][31:0] ma_wdata, dbg_wdata;
    wire  [1:0]       ma_ready, ma_stall, dbg_ready, mem_en, mem_we;
    wire  [1:0][31:0] ma_rdata, dbg_rdata, mem_din;
    wire  [1:0][6:0]  mem_addr;
    logic [31:0]      dout0, dout1;

    int checks = 0;
    int failures = 0;

    logic [31:0] ref_mem [2][128];
    bit          valid   [2][128];
    logic [31:0] exp_rd  [2][2];
    int          last_win [2];

    always #5 clk = ~clk;

    dmem_access_ctrl #(.ADDR_W(7), .DATA_W(32), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .ma_req(ma_req[0]), .ma_we(ma_we[0]), .ma_addr(ma_addr[0]), .ma_wdata(ma_wdata[0]),
        .ma_ready(ma_ready[0]), .ma_rdata(ma_rdata[0]), .ma_stall(ma_stall[0]),
        .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]), .dbg_wdata(dbg_wdata[0]),
        .dbg_ready(dbg_ready[0]), .dbg_rdata(dbg_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]),
        .mem_dout(dout0)
    );

    dmem_access_ctrl #(.ADDR_W(7), .DATA_W(32), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .ma_req(ma_req[1]), .ma_we(ma_we[1]), .ma_addr(ma_addr[1]), .ma_wdata(ma_wdata[1]),
        .ma_ready(ma_ready[1]), .ma_rdata(ma_rdata[1]), .ma_stall(ma_stall[1]),
        .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]), .dbg_wdata(dbg_wdata[1]),
        .dbg_ready(dbg_ready[1]), .dbg_rdata(dbg_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]),
        .mem_dout(dout1)
    );

    // BRAM models: read data lives in the output stage for one cycle only, garbage otherwise.
    logic [31:0] bram0 [128];
    logic [31:0] bram1 [128];
    logic [31:0] p0_s1, p1_s1, p1_s2, p1_s3;

    always @(posedge clk) begin
        if (mem_en[0] && mem_we[0]) bram0[mem_addr[0]] <= mem_din[0];
        p0_s1 <= (mem_en[0] && !mem_we[0]) ? bram0[mem_addr[0]] : $urandom;
        if (mem_en[1] && mem_we[1]) bram1[mem_addr[1]] <= mem_din[1];
        p1_s1 <= (mem_en[1] && !mem_we[1]) ? bram1[mem_addr[1]] : $urandom;
        p1_s2 <= p1_s1;
        p1_s3 <= p1_s2;
    end
    assign dout0 = p0_s1;
    assign dout1 = p1_s3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input int i, input bit we);
        return we ? 2 : (((i == 0) ? 1 : 3) + 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            last_win[i] = 1;
            exp_rd[i][0] = '0;
            exp_rd[i][1] = '0;
        end
    endtask

    task automatic apply(input int i, input int p, input bit we, input logic [6:0] a,
                         input logic [31:0] d, output logic [31:0] x);
        if (we) begin
            ref_mem[i][a] = d;
            valid[i][a] = 1'b1;
            x = exp_rd[i][p];
        end else begin
            x = ref_mem[i][a];
            exp_rd[i][p] = x;
        end
    endtask

    // One access per active port, both launched together; second is served after the first completes.
    task automatic run(input int i,
                       input bit m_on, input bit m_w, input logic [6:0] m_a, input logic [31:0] m_d,
                       input bit d_on, input bit d_w, input logic [6:0] d_a, input logic [31:0] d_d);
        int tm, td, cm, cd, em, ed;
        logic [31:0] rm, rd, xm, xd;
        em = -1; ed = -1; xm = '0; xd = '0;
        if (m_on && (!d_on || last_win[i] == 1)) begin
            em = lat(i, m_w);
            apply(i, 0, m_w, m_a, m_d, xm);
            if (d_on) begin
                ed = em + 1 + lat(i, d_w);
                apply(i, 1, d_w, d_a, d_d, xd);
            end
            last_win[i] = d_on ? 1 : 0;
        end else begin
            ed = lat(i, d_w);
            apply(i, 1, d_w, d_a, d_d, xd);
            if (m_on) begin
                em = ed + 1 + lat(i, m_w);
                apply(i, 0, m_w, m_a, m_d, xm);
            end
            last_win[i] = m_on ? 0 : 1;
        end
        ma_req[i] = m_on;   ma_we[i] = m_w;   ma_addr[i] = m_a;   ma_wdata[i] = m_d;
        dbg_req[i] = d_on;  dbg_we[i] = d_w;  dbg_addr[i] = d_a;  dbg_wdata[i] = d_d;
        tm = -1; td = -1; cm = 0; cd = 0; rm = '0; rd = '0;
        for (int n = 0; n < 40; n++) begin
            bit done;
            @(negedge clk);
            if (ma_ready[i]) begin
                cm++;
                if (tm < 0) begin tm = n; rm = ma_rdata[i]; end
            end
            if (dbg_ready[i]) begin
                cd++;
                if (td < 0) begin td = n; rd = dbg_rdata[i]; end
            end
            done = (!m_on || tm >= 0) && (!d_on || td >= 0);
            tick();
            if (tm >= 0) ma_req[i] = 1'b0;
            if (td >= 0) dbg_req[i] = 1'b0;
            if (done) break;
        end
        if (m_on) begin
            chk($sformatf("i%0d ma_lat", i), tm, em);
            if (!m_w) chk($sformatf("i%0d ma_load a=%h", i, m_a), rm, xm);
        end
        if (d_on) begin
            chk($sformatf("i%0d dbg_lat", i), td, ed);
            if (!d_w) chk($sformatf("i%0d dbg_read a=%h", i, d_a), rd, xd);
        end
        chk($sformatf("i%0d ma_ready_count", i), cm, {31'd0, m_on});
        chk($sformatf("i%0d dbg_ready_count", i), cd, {31'd0, d_on});
        chk($sformatf("i%0d ma_rdata_hold", i), ma_rdata[i], exp_rd[i][0]);
        chk($sformatf("i%0d dbg_rdata_hold", i), dbg_rdata[i], exp_rd[i][1]);
    endtask

    initial begin
        int tm, td, k, port, prev_port;
        logic [31:0] rm, ad;
        logic en7;
        reset = 1'b1;
        ma_req = '0; ma_we = '0; dbg_req = '0; dbg_we = '0;
        ma_addr = '0; dbg_addr = '0; ma_wdata = '0; dbg_wdata = '0;
        model_reset();
        ma_req[0] = 1'b1;
        #12;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("i%0d rst mem_en", i), mem_en[i], 0);
            chk($sformatf("i%0d rst mem_we", i), mem_we[i], 0);
            chk($sformatf("i%0d rst mem_addr", i), mem_addr[i], 0);
            chk($sformatf("i%0d rst mem_din", i), mem_din[i], 0);
            chk($sformatf("i%0d rst ready", i), {ma_ready[i], dbg_ready[i]}, 0);
            chk($sformatf("i%0d rst rdata", i), ma_rdata[i] | dbg_rdata[i], 0);
        end
        chk("rst stall follows req", ma_stall[0], 1);
        ma_req[0] = 1'b0;
        #1;
        chk("rst stall low", ma_stall[0], 0);
        tick();
        reset = 1'b0;
        tick();

        // Both ports hold requests continuously: strict alternation, MA first.
        ma_req[0] = 1; ma_we[0] = 1; ma_addr[0] = 7'h10; ma_wdata[0] = 32'h1;
        dbg_req[0] = 1; dbg_we[0] = 1; dbg_addr[0] = 7'h11; dbg_wdata[0] = 32'h2;
        k = 0;
        port = 1 - last_win[0];
        prev_port = port;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ma_ready[0] || dbg_ready[0]) begin
                chk($sformatf("rr ready#%0d port", k), {ma_ready[0], dbg_ready[0]},
                    (port == 0) ? 2 : 1);
                chk($sformatf("rr ready#%0d time", k), n, 2 + 3 * k);
                prev_port = port;
                port = 1 - port;
                k++;
            end
            tick();
            if (k == 6) break;
        end
        ma_req[0] = 0; dbg_req[0] = 0;
        chk("rr ready total", k, 6);
        last_win[0] = prev_port;
        ref_mem[0][7'h10] = 32'h1; valid[0][7'h10] = 1;
        ref_mem[0][7'h11] = 32'h2; valid[0][7'h11] = 1;
        chk("rr bram 0x10", bram0[7'h10], ref_mem[0][7'h10]);
        chk("rr bram 0x11", bram0[7'h11], ref_mem[0][7'h11]);

        // Cycle-accurate MA store then load at RD_LAT=1.
        ma_req[0] = 1; ma_we[0] = 1; ma_addr[0] = 7'h05; ma_wdata[0] = 32'hDEADBEEF;
        @(negedge clk);
        chk("st c0 mem_en", mem_en[0], 0);
        chk("st c0 stall", ma_stall[0], 1);
        tick();
        @(negedge clk);
        chk("st c1 en/we", {mem_en[0], mem_we[0]}, 3);
        chk("st c1 addr", mem_addr[0], 7'h05);
        chk("st c1 din", mem_din[0], 32'hDEADBEEF);
        chk("st c1 stall", ma_stall[0], 1);
        tick();
        @(negedge clk);
        chk("st c2 ready", ma_ready[0], 1);
        chk("st c2 stall", ma_stall[0], 0);
        chk("st c2 mem_en", mem_en[0], 0);
        tick();
        ma_req[0] = 0;
        ref_mem[0][7'h05] = 32'hDEADBEEF; valid[0][7'h05] = 1; last_win[0] = 0;
        ma_req[0] = 1; ma_we[0] = 0;
        @(negedge clk);
        chk("ld c0 ready", ma_ready[0], 0);
        tick();
        @(negedge clk);
        chk("ld c1 en/we", {mem_en[0], mem_we[0]}, 2);
        tick();
        @(negedge clk);
        chk("ld c2 ready", ma_ready[0], 0);
        tick();
        @(negedge clk);
        chk("ld c3 ready", ma_ready[0], 1);
        chk("ld c3 rdata", ma_rdata[0], 32'hDEADBEEF);
        chk("ld c3 dbg_ready", dbg_ready[0], 0);
        tick();
        ma_req[0] = 0;
        exp_rd[0][0] = 32'hDEADBEEF;
        tick();
        @(negedge clk);
        chk("ld rdata held", ma_rdata[0], 32'hDEADBEEF);
        tick();

        // RD_LAT=3: debug write/read, then MA load of a debug-written word.
        run(1, 0, 0, 0, 0, 1, 1, 7'h20, 32'hCAFEF00D);
        run(1, 0, 0, 0, 0, 1, 0, 7'h20, 0);
        run(1, 0, 0, 0, 0, 1, 1, 7'h7F, 32'h12345678);
        run(1, 1, 0, 7'h7F, 0, 0, 0, 0, 0);
        chk("lat3 ma_rdata", ma_rdata[1], 32'h12345678);
        chk("lat3 dbg_rdata kept", dbg_rdata[1], 32'hCAFEF00D);

        // Reset during WAIT of a load.
        ma_req[1] = 1; ma_we[1] = 0; ma_addr[1] = 7'h7F;
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("wrst en/we", {mem_en[1], mem_we[1]}, 0);
        chk("wrst addr", mem_addr[1], 0);
        chk("wrst din", mem_din[1], 0);
        chk("wrst ma_rdata", ma_rdata[1], 0);
        chk("wrst dbg_rdata", dbg_rdata[1], 0);
        chk("wrst stall", ma_stall[1], 1);
        ma_req[1] = 0;
        #1;
        chk("wrst stall low", ma_stall[1], 0);
        tick();
        reset = 1'b0;
        model_reset();
        k = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ma_ready[1] || dbg_ready[1]) k++;
            tick();
        end
        chk("wrst no ready", k, 0);

        // Reset while a store sits in ISSUE: the write must not land.
        run(1, 0, 0, 0, 0, 1, 1, 7'h30, 32'h11111111);
        ma_req[1] = 1; ma_we[1] = 1; ma_addr[1] = 7'h30; ma_wdata[1] = 32'hBAD0BAD0;
        tick();
        @(negedge clk);
        chk("irst pre en/we", {mem_en[1], mem_we[1]}, 3);
        #1;
        reset = 1'b1;
        #1;
        chk("irst en/we drop", {mem_en[1], mem_we[1]}, 0);
        ma_req[1] = 0;
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        run(1, 1, 0, 7'h30, 0, 0, 0, 0, 0);
        run(1, 0, 0, 0, 0, 1, 0, 7'h30, 0);

        // MA load with dbg queued; MA drops req mid-WAIT.
        ma_req[1] = 1; ma_we[1] = 0; ma_addr[1] = 7'h30;
        dbg_req[1] = 1; dbg_we[1] = 1; dbg_addr[1] = 7'h40; dbg_wdata[1] = 32'h55AA55AA;
        tm = -1; td = -1; rm = '0; ad = '0; en7 = 1'b0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (ma_ready[1] && tm < 0) begin tm = n; rm = ma_rdata[1]; end
            if (dbg_ready[1] && td < 0) td = n;
            if (n == 7) begin en7 = mem_en[1]; ad = {25'd0, mem_addr[1]}; end
            tick();
            if (n == 1) ma_req[1] = 0;
            if (td >= 0) begin dbg_req[1] = 0; break; end
        end
        chk("drop ma_ready time", tm, 5);
        chk("drop ma_rdata", rm, ref_mem[1][7'h30]);
        chk("drop dbg issue en", en7, 1);
        chk("drop dbg issue addr", ad, 7'h40);
        chk("drop dbg_ready time", td, 8);
        ref_mem[1][7'h40] = 32'h55AA55AA; valid[1][7'h40] = 1;
        exp_rd[1][0] = ref_mem[1][7'h30];
        last_win[1] = 1;

        // Randomized mix of single and contended accesses on both instances.
        for (int it = 0; it < 80; it++) begin
            int i, mode;
            bit mw, dw;
            logic [6:0] ma, da;
            i = $urandom_range(0, 1);
            mode = $urandom_range(0, 2);
            mw = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            ma = 7'($urandom_range(0, 15));
            da = 7'($urandom_range(0, 15));
            if (!mw && !valid[i][ma]) mw = 1'b1;
            if (!dw && !valid[i][da]) dw = 1'b1;
            run(i, mode != 1, mw, ma, $urandom, mode != 0, dw, da, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequencer and arbiter for the single-port data memory (BRAM, 128 x 32).
- Shares the memory between two requesters:
  - the pipeline memory-access stage (ma_*), and
  - a debug/loader port (dbg_*).
- Owns all memory enable, write, address and data strobes, and absorbs the BRAM read latency.
- Returns a one-cycle ready pulse to the requester, plus a stall for the pipeline.

Parameters:
- ADDR_W, 7, data memory word-address width.
- DATA_W, 32, data word width.
- RD_LAT, 1, BRAM read latency in clocks (legal 1..3).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ma_req  in  1  MA-stage access request (load or store).
- ma_we  in  1  1 = store, 0 = load.
- ma_addr  in  ADDR_W  MA word address.
- ma_wdata  in  DATA_W  MA store data.
- ma_ready  out  1  one-cycle completion pulse to MA.
- ma_rdata  out  DATA_W  MA load data, valid when ma_ready=1, held afterwards.
- ma_stall  out  1  pipeline stall (combinational: ma_req & ~ma_ready).
- dbg_req  in  1  debug access request.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  ADDR_W  debug word address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_ready  out  1  one-cycle completion pulse to debug.
- dbg_rdata  out  DATA_W  debug read data, valid when dbg_ready=1, held afterwards.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_din  out  DATA_W  BRAM write data.
- mem_dout  in  DATA_W  BRAM read data.

Behaviour:
- **Reset values:** all outputs 0 except ma_stall, which follows ma_req. State=IDLE, last_grant=DBG (so MA wins the first tie), latched command cleared.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - No request: stay.
  - One requester: grant it.
  - Both requesting: grant the port not equal to last_grant (round-robin).
  - On grant: latch we/addr/wdata and the granted id, update last_grant, go to ISSUE.
- **ISSUE:**
  - mem_en=1 for exactly this cycle; mem_we = latched we; mem_addr/mem_din = latched values.
  - Write: go to RESP.
  - Read: load wait counter with RD_LAT-1, go to WAIT.
- **WAIT:**
  - mem_en=0.
  - Decrement the counter each cycle. At the cycle where the counter is 0, capture mem_dout into the granted port's rdata register on the closing edge, then go to RESP.
  - mem_dout is sampled exactly RD_LAT edges after the ISSUE edge.
- **RESP:**
  - The granted port's ready=1 for one cycle; go to IDLE.
  - The other port's ready stays 0.
- **Latency, from the req-high cycle in IDLE to the ready cycle:**
  - write: 2 cycles (ready in cycle 2)
  - read: RD_LAT+2 cycles (ready in cycle RD_LAT+2)
- mem_en/mem_we are 0 in every state except ISSUE. mem_addr/mem_din hold the latched values in all states.
- Only one transaction is in flight at a time. No request is accepted outside IDLE. The non-granted request waits with no loss.
- **Requester contract:**
  - Hold req/we/addr/wdata stable until ready.
  - Drop req in the cycle after ready, unless issuing a new access. req still high in the IDLE cycle after RESP counts as a new request.
  - Minimum spacing between back-to-back accesses from the same port is 3 cycles (write) and RD_LAT+3 cycles (read).
- A req deasserted mid-transaction is ignored: the latched command completes and ready still pulses.
- rdata registers change only on a completed read for that port. Writes leave rdata unchanged.
- Starvation bound: with both ports requesting continuously, grants alternate strictly.
- **Reset mid-operation (asynchronous):**
  - FSM goes to IDLE and mem_en/mem_we drop immediately.
  - No ready is generated.
  - A pending write not yet at ISSUE is not performed.

Test Plan:
- MA store addr=0x05 data=0xDEADBEEF, RD_LAT=1 → mem_en=mem_we=1 for one cycle with addr 0x05; ma_ready in cycle 2; ma_stall=1 in cycles 0..1 and 0 in cycle 2.
- MA load addr=0x05 after the store, RD_LAT=1 → mem_en=1 and mem_we=0 in cycle 1; ma_ready in cycle 3 with ma_rdata=0xDEADBEEF; ma_rdata held after req drops.
- ma_req and dbg_req asserted together and held continuously (MA write 0x10 := 0x1, dbg write 0x11 := 0x2, reissued each time) → first grant MA, then dbg, then MA; each ready pulses only on its own port; no lost access.
- dbg write 0x7F := 0x12345678, then MA load 0x7F with RD_LAT=3 → ma_ready 5 cycles after the load request with ma_rdata=0x12345678; dbg_rdata unchanged.
- MA load issued, reset pulsed during WAIT (RD_LAT=3) → mem_en=0 immediately, no ma_ready, all outputs at reset values; a fresh load after reset completes normally.
- ma_req dropped during WAIT → ma_ready still pulses at the scheduled cycle; the FSM returns to IDLE and accepts a queued dbg_req on the next cycle.
